// File: rtl/serial_collector.sv
// serial_collector: assembles 16 LSB-first serial bits into a parallel word with an out_valid/ack handoff.
// Optional feature macro SERIAL_COLLECTOR_OVERFLOW_EN adds carry_in/overflow capture on the 16th bit.
module serial_collector (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        ack,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        busy,
    output logic [3:0]  bit_count,
    output logic [1:0]  state_dbg
`ifdef SERIAL_COLLECTOR_OVERFLOW_EN
    ,
    input  logic        carry_in,
    output logic        overflow
`endif
);

    // Handshake: a completed word is offered while out_valid=1 and stays stable
    // until ack is sampled high on a clock edge; ack while out_valid=0 is ignored.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   do_clear;
    logic   do_shift;
    logic   last_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start outranks bit_valid in SHIFT; in FULL only ack can release the word.
    always_comb begin
        next_state = state;
        do_clear   = 1'b0;
        do_shift   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_SHIFT;
                    do_clear   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    do_clear = 1'b1;
                end else if (bit_valid) begin
                    do_shift = 1'b1;
                    if (bit_count == 4'd15) begin
                        next_state = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (ack) begin
                    if (start) begin
                        next_state = ST_SHIFT;
                        do_clear   = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state == ST_SHIFT);
        out_valid = (state == ST_FULL);
        state_dbg = state;
    end

    assign last_bit = do_shift && (bit_count == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= 16'h0000;
            bit_count <= 4'd0;
        end else if (do_clear) begin
            out       <= 16'h0000;
            bit_count <= 4'd0;
        end else if (do_shift) begin
            out       <= {bit_in, out[15:1]};
            bit_count <= bit_count + 4'd1;
        end
    end

`ifdef SERIAL_COLLECTOR_OVERFLOW_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (do_clear) begin
            overflow <= 1'b0;
        end else if (last_bit) begin
            overflow <= carry_in;
        end
    end
`else
    logic unused_last_bit;
    assign unused_last_bit = last_bit;
`endif

endmodule

// File: tb/tb_serial_collector.sv
// Bench for serial_collector: directed scenarios plus randomized captures checked against a bit-queue model.
// Builds with or without SERIAL_COLLECTOR_OVERFLOW_EN.
module tb_serial_collector;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        bit_in;
    logic        bit_valid;
    logic        ack;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;
    logic [3:0]  bit_count;
    logic [1:0]  state_dbg;
`ifdef SERIAL_COLLECTOR_OVERFLOW_EN
    logic        carry_in;
    logic        overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    // Reference model: the accepted bits of the current capture, in arrival order.
    logic [1:0]  m_st;
    bit          m_bits[$];
    logic [15:0] m_word;
    bit          m_ovf;
    bit          m_just_full;

    serial_collector dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .ack       (ack),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .bit_count (bit_count),
        .state_dbg (state_dbg)
`ifdef SERIAL_COLLECTOR_OVERFLOW_EN
        ,
        .carry_in  (carry_in),
        .overflow  (overflow)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] bits_value();
        int n = m_bits.size();
        logic [31:0] w = 32'd0;
        for (int j = 0; j < n; j++) begin
            w = w | (32'(m_bits[j]) << (16 - n + j));
        end
        return w[15:0];
    endfunction

    function automatic logic [15:0] model_out();
        if (m_st == S_SHIFT) return bits_value();
        return m_word;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE;
        m_bits.delete();
        m_word = 16'h0000;
        m_ovf = 1'b0;
    endtask

    task automatic model_begin();
        m_st = S_SHIFT;
        m_bits.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit bv, input bit bi, input bit a, input bit c);
        m_just_full = 1'b0;
        case (m_st)
            S_IDLE: if (s) model_begin();
            S_SHIFT: begin
                if (s) begin
                    model_begin();
                end else if (bv) begin
                    m_bits.push_back(bi);
                    if (m_bits.size() == 16) begin
                        m_word = bits_value();
                        m_ovf = c;
                        m_st = S_FULL;
                        m_just_full = 1'b1;
                    end
                end
            end
            default: begin
                if (a) begin
                    if (s) model_begin();
                    else m_st = S_IDLE;
                end
            end
        endcase
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, 32'(out), 32'(model_out()));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_st == S_FULL));
        check({tag, ".busy"}, 32'(busy), 32'(m_st == S_SHIFT));
        check({tag, ".bit_count"}, 32'(bit_count), 32'(m_bits.size() % 16));
        check({tag, ".state"}, 32'(state_dbg), 32'(m_st));
`ifdef SERIAL_COLLECTOR_OVERFLOW_EN
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`endif
    endtask

    // driver tasks
    task automatic step(input string tag, input bit s, input bit bv, input bit bi, input bit a, input bit c);
        start = s;
        bit_valid = bv;
        bit_in = bi;
        ack = a;
`ifdef SERIAL_COLLECTOR_OVERFLOW_EN
        carry_in = c;
`endif
        @(posedge clk);
        model_edge(s, bv, bi, a, c);
        #1;
        check_all(tag);
        if (m_just_full) begin
            if (exp_q.size() == 0) begin
                check({tag, ".sb_empty"}, 32'(out), 32'hFFFF_FFFF);
            end else begin
                check({tag, ".sb_word"}, 32'(out), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic send_bits(input string tag, input logic [15:0] w, input int n,
                             input int gmin, input int gmax, input bit c_last);
        logic [15:0] wv;
        wv = w;
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(gmax, gmin);
            for (int k = 0; k < g; k++) begin
                step({tag, ".gap"}, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            step({tag, ".bit"}, 1'b0, 1'b1, wv[i], 1'b0, (i == 15) ? c_last : 1'($urandom));
        end
    endtask

    task automatic send_word(input string tag, input logic [15:0] w, input int gmin, input int gmax,
                             input bit c_last);
        exp_q.push_back(w);
        send_bits(tag, w, 16, gmin, gmax, c_last);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        ack = 1'b0;
`ifdef SERIAL_COLLECTOR_OVERFLOW_EN
        carry_in = 1'b0;
`endif
        model_reset();
        m_just_full = 1'b0;
        #1;
        check_all("por");
        @(posedge clk);
        #1;
        check_all("por_held");
        reset = 1'b0;

        // Reset after 7 bits discards the partial capture at once.
        step("rst7.start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits("rst7", 16'($urandom), 7, 0, 1, 1'b0);
        mid_cycle_reset("rst7.async");
        step("rst7.idle_edge", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Back-to-back bits of 16'hA5C3, then release.
        step("a5c3.start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word("a5c3", 16'hA5C3, 0, 0, 1'b0);
        check("a5c3.word", 32'(out), 32'h0000_A5C3);
        step("a5c3.ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Same word with 1-3 cycle gaps, then FULL ignores bits and a lone start.
        step("gap.start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word("gap", 16'hA5C3, 1, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("full.extra_bit", 1'b0, 1'b1, 1'($urandom), 1'b0, 1'($urandom));
        end
        step("full.start_no_ack", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full.hold", 32'(out), 32'h0000_A5C3);
        step("full.ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("idle.retain", 32'(out), 32'h0000_A5C3);
        step("idle.ack_ignored", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Restart after 9 ones, capture 16'h0001, then ack+start together.
        step("rs.start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits("rs.ones", 16'hFFFF, 9, 0, 0, 1'b0);
        step("rs.restart", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word("rs.one", 16'h0001, 0, 1, 1'b0);
        check("rs.word", 32'(out), 32'h0000_0001);
        step("rs.ack_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rs.cleared", 32'(out), 32'h0000_0000);
        mid_cycle_reset("rs.reset");

`ifdef SERIAL_COLLECTOR_OVERFLOW_EN
        step("ovf.start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word("ovf", 16'h8000, 0, 1, 1'b1);
        check("ovf.set", 32'(overflow), 32'd1);
        step("ovf.ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("ovf.idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ovf.restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf.cleared", 32'(overflow), 32'd0);
        send_word("ovf2", 16'h7FFF, 0, 0, 1'b0);
        step("ovf2.ack", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized captures with gaps, noise while FULL and optional back-to-back restarts.
        begin
            bit b2b = 1'b0;
            for (int r = 0; r < 12; r++) begin
                if (!b2b) begin
                    int idle_n = $urandom_range(2, 0);
                    for (int k = 0; k < idle_n; k++) begin
                        step("rnd.idle", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                    end
                    step("rnd.start", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
                send_word("rnd", 16'($urandom), 0, 2, 1'($urandom));
                for (int k = 0; k < int'($urandom_range(3, 0)); k++) begin
                    step("rnd.full", 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
                end
                b2b = 1'($urandom);
                step("rnd.ack", b2b, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
